// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the word-level serial adder sequencer.
package serial_add_pkg;

  typedef enum logic [1:0] {IDLE, PRELOAD, SHIFT, DONE} sa_state_t;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// Parallel-load, LSB-first right-shift register with serial in and out.
module serial_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_data,
  input  logic             serial_in,
  output logic             serial_out,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift) begin
      q <= {serial_in, q[WIDTH-1:1]};
    end
  end

  assign serial_out = q[0];

endmodule

// File: rtl/serial_add_ctrl.sv
// Sequences one WIDTH-bit addition through an external 1-bit serial adder cell,
// LSB first, with valid/ready handshakes on the operand and result sides.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             add_a,
  output logic             add_b,
  output logic             add_clr,
  input  logic             add_s,
  input  logic             add_cout,
  output logic             busy
);

  localparam int            CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sa_state_t        state_reg, state_next;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] out_sum_reg;
  logic             out_cout_reg;
  logic [WIDTH-1:0] a_q, b_q, s_q;
  logic             a_bit, b_bit, s_bit;
  logic             accept, shifting, last_bit;

  assign accept   = in_valid & in_ready;
  assign shifting = (state_reg == SHIFT);
  assign last_bit = shifting && (cnt_reg == LAST);

  serial_shift_reg #(.WIDTH(WIDTH)) u_a_sr (
    .clock(clock), .reset(reset), .load(accept), .shift(shifting),
    .load_data(in_a), .serial_in(1'b0), .serial_out(a_bit), .q(a_q)
  );

  serial_shift_reg #(.WIDTH(WIDTH)) u_b_sr (
    .clock(clock), .reset(reset), .load(accept), .shift(shifting),
    .load_data(in_b), .serial_in(1'b0), .serial_out(b_bit), .q(b_q)
  );

  serial_shift_reg #(.WIDTH(WIDTH)) u_s_sr (
    .clock(clock), .reset(reset), .load(accept), .shift(shifting),
    .load_data('0), .serial_in(add_s), .serial_out(s_bit), .q(s_q)
  );

  // Only the serial ends of A/B and the upper bits of the sum register are consumed.
  logic unused_bits;
  assign unused_bits = ^{a_q, b_q, s_q[0], s_bit};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (accept) state_next = in_cin ? PRELOAD : SHIFT;
      PRELOAD: state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    add_a     = 1'b0;
    add_b     = 1'b0;
    add_clr   = 1'b1;
    unique case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      // Driving 1+1 with a cleared carry makes the adder store carry=1.
      PRELOAD: begin
        add_a   = 1'b1;
        add_b   = 1'b1;
        add_clr = 1'b0;
      end
      SHIFT: begin
        add_a   = a_bit;
        add_b   = b_bit;
        add_clr = 1'b0;
      end
      DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else if (accept) begin
      cnt_reg <= '0;
    end else if (shifting) begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  // The final sum bit is still combinational on add_s, so it is merged in here.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_sum_reg  <= '0;
      out_cout_reg <= 1'b0;
    end else if (last_bit) begin
      out_sum_reg  <= {add_s, s_q[WIDTH-1:1]};
      out_cout_reg <= add_cout;
    end
  end

  assign out_sum  = out_sum_reg;
  assign out_cout = out_cout_reg;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl with a behavioural 1-bit adder and a result queue.
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             in_cin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             add_a, add_b, add_clr, add_s, add_cout;
  logic             busy;

  logic             c_reg = 1'b0;
  logic [WIDTH:0]   exp_q[$];
  logic [WIDTH:0]   last_exp;
  int               checks = 0;
  int               failures = 0;

  always #5 clock = ~clock;

  // Adder cell model: combinational sum/carry, carry register with sync clear.
  assign add_s    = add_a ^ add_b ^ c_reg;
  assign add_cout = (add_a & add_b) | (add_a & c_reg) | (add_b & c_reg);
  always @(posedge clock) c_reg <= add_clr ? 1'b0 : add_cout;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout),
    .add_a(add_a), .add_b(add_b), .add_clr(add_clr),
    .add_s(add_s), .add_cout(add_cout),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"},  in_ready,  1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_sum"},   out_sum,   0);
    chk({tag, "_out_cout"},  out_cout,  0);
    chk({tag, "_add_a"},     add_a,     0);
    chk({tag, "_add_b"},     add_b,     0);
    chk({tag, "_add_clr"},   add_clr,   1);
    chk({tag, "_busy"},      busy,      0);
  endtask

  // Present a word, wait for the accept edge, push the expected result; returns 1 time unit after it.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic cin, input bit hold);
    int n;
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    for (n = 0; n < 50; n++) begin
      @(negedge clock);
      if (in_ready) break;
    end
    chk("accept_timeout", (n < 50), 1);
    @(posedge clock);
    exp_q.push_back({1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin});
    #1;
    if (!hold) in_valid = 1'b0;
  endtask

  // Count edges from the accept edge to out_valid, then compare against the queue head.
  task automatic wait_result(input string tag, input int exp_lat);
    int n;
    n = 0;
    while (n < 40) begin
      @(posedge clock);
      n++;
      #1;
      if (out_valid) break;
    end
    chk({tag, "_latency"}, n, exp_lat);
    chk({tag, "_queue"}, (exp_q.size() > 0), 1);
    last_exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    chk({tag, "_sum"},  out_sum,  last_exp[WIDTH-1:0]);
    chk({tag, "_cout"}, out_cout, last_exp[WIDTH]);
    $display("txn %s: sum=%02h cout=%0d latency=%0d", tag, out_sum, out_cout, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    #12;
    chk_reset_vals("reset");
    @(negedge clock);
    reset = 1'b1;

    // 1: plain add, no carry-in
    send(8'h35, 8'h0A, 1'b0, 1'b0);
    chk("t1_busy", busy, 1);
    chk("t1_in_ready_busy", in_ready, 0);
    wait_result("t1", 8);
    @(posedge clock); #1;
    chk("t1_back_idle", in_ready, 1);

    // 2: carry ripples out, cin=0 so no PRELOAD cycle
    send(8'hFF, 8'h01, 1'b0, 1'b0);
    wait_result("t2", 8);
    @(posedge clock); #1;

    // 3: carry-in through PRELOAD
    send(8'hFF, 8'h00, 1'b1, 1'b0);
    wait_result("t3", 9);
    @(posedge clock); #1;

    // 4: backpressure holds the result
    out_ready = 1'b0;
    send(8'h80, 8'h80, 1'b0, 1'b0);
    wait_result("t4", 8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("t4_hold_valid", out_valid, 1);
      chk("t4_hold_sum", out_sum, last_exp[WIDTH-1:0]);
      chk("t4_hold_cout", out_cout, last_exp[WIDTH]);
      chk("t4_hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    chk("t4_released", out_valid, 0);

    // 5: asynchronous reset mid-SHIFT, then a clean word
    send(8'h55, 8'h33, 1'b0, 1'b0);
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_vals("t5_reset");
    exp_q.delete();
    @(negedge clock);
    reset = 1'b1;
    send(8'h01, 8'h01, 1'b0, 1'b0);
    wait_result("t5", 8);
    @(posedge clock); #1;

    // 6: in_valid held high across two back-to-back words
    send(8'h10, 8'h01, 1'b0, 1'b1);
    in_a = 8'hF0; in_b = 8'h20; in_cin = 1'b1;
    wait_result("t6a", 8);
    @(posedge clock); #1;
    chk("t6_idle_gap", in_ready, 1);
    @(posedge clock);
    exp_q.push_back({1'b0, 8'hF0} + {1'b0, 8'h20} + 9'd1);
    #1;
    chk("t6_second_accept", in_ready, 0);
    in_valid = 1'b0;
    wait_result("t6b", 9);
    @(posedge clock); #1;
    chk("t6_final_idle", in_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
